// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the parametrised PCI bus arbiter.
package pci_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        StPark,
        StGrant,
        StBusy
    } arb_state_e;

    // Winner-selection policy encodings
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of the grant idle counter
    localparam int unsigned CNT_W = 8;

    // Ceiling log2, never smaller than 1 so a 2-master index still has a bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pci_arb_pick.sv
// Combinational winner selection: fixed priority (highest index) or
// round-robin starting at a given pointer, with an exclusion mask.
module pci_arb_pick
    import pci_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 5,
    parameter int unsigned IW          = 3
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          start,
    input  logic [NUM_MASTERS-1:0] excl,
    input  logic                   mode,
    output logic [NUM_MASTERS-1:0] win,
    output logic                   valid
);

    logic [NUM_MASTERS-1:0] cand;
    logic [NUM_MASTERS-1:0] rot_lo;
    logic [NUM_MASTERS-1:0] oh_lo;
    logic [NUM_MASTERS-1:0] win_rr;
    logic [NUM_MASTERS-1:0] win_fix;

    assign cand  = req & ~excl;
    assign valid = |cand;

    // Round-robin: rotate so 'start' lands at bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot_lo = NUM_MASTERS'({cand, cand} >> start);
        oh_lo  = rot_lo & (~rot_lo + 1'b1);
        win_rr = NUM_MASTERS'(({oh_lo, oh_lo} << start) >> NUM_MASTERS);
    end

    // Fixed priority: the last (highest) candidate seen wins
    always_comb begin
        win_fix = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (cand[i]) begin
                win_fix    = '0;
                win_fix[i] = 1'b1;
            end
        end
    end

    assign win = (mode == MODE_RR) ? win_rr : win_fix;

endmodule

// File: rtl/pci_arbiter_param.sv
// PCI REQ#/GNT# arbiter with parking, hidden arbitration, turnaround
// insertion between different grantees and a grant timeout.
module pci_arbiter_param
    import pci_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 5,
    parameter int unsigned RR_MODE     = 0,
    parameter int unsigned PARK_EN     = 1,
    parameter int unsigned PARK_MASTER = 4,
    parameter int unsigned GNT_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        req_n,
    input  logic                          frame_n,
    input  logic                          irdy_n,
    output logic [NUM_MASTERS-1:0]        gnt_n,
    output logic [clog2(NUM_MASTERS)-1:0] owner,
    output logic                          owner_valid,
    output logic                          timeout_pulse
);

    localparam int unsigned IW = clog2(NUM_MASTERS);
    localparam logic [IW-1:0] PARK_IDX = IW'(PARK_MASTER);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(GNT_TIMEOUT);
    localparam logic TMO_EN            = (GNT_TIMEOUT != 0);
    localparam logic MODE              = (RR_MODE != 0) ? MODE_RR : MODE_FIXED;
    localparam logic [NUM_MASTERS-1:0] PARK_OH =
        (PARK_EN != 0) ? (NUM_MASTERS'(1) << PARK_MASTER) : '0;

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] gnt_q;      // active-high grant register
    logic [IW-1:0]          win_q;      // grant target while in StGrant
    logic [IW-1:0]          own_q;
    logic                   ov_q;
    logic [IW-1:0]          last_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   tmo_q;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] excl;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [NUM_MASTERS-1:0] own_oh;
    logic [NUM_MASTERS-1:0] want;
    logic [NUM_MASTERS-1:0] gnt_next;
    logic [IW-1:0]          pick_idx;
    logic [IW-1:0]          start;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   pick_valid;
    logic                   bus_idle;
    logic                   park_start;
    logic                   tmo_hit;
    logic                   grant_rearb;

    assign req        = ~req_n;
    assign bus_idle   = frame_n & irdy_n;
    assign win_oh     = NUM_MASTERS'(1) << win_q;
    assign own_oh     = NUM_MASTERS'(1) << own_q;
    assign start      = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
    assign cnt_inc    = (cnt_q < TMO) ? cnt_q + 1'b1 : cnt_q;
    // The current owner (busy) or current target (grant) never competes with itself
    assign excl       = (state_q == StBusy)  ? own_oh :
                        (state_q == StGrant) ? win_oh : '0;
    // The parked master may start a transaction without requesting
    assign park_start = !frame_n && (PARK_EN != 0) && gnt_q[PARK_MASTER];
    assign tmo_hit    = TMO_EN && (state_q == StGrant) && bus_idle && gnt_q[win_q] &&
                        req[win_q] && (cnt_inc == TMO);
    assign grant_rearb = !req[win_q] || tmo_hit;

    pci_arb_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .IW         (IW)
    ) u_pick (
        .req  (req),
        .start(start),
        .excl (excl),
        .mode (MODE),
        .win  (pick_oh),
        .valid(pick_valid)
    );

    // One-hot winner to index
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_oh[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

    // Desired grant this cycle; a change between two masters first passes through all-off
    always_comb begin
        want = gnt_q;
        unique case (state_q)
            StPark: begin
                want = (pick_valid && !park_start) ? pick_oh : PARK_OH;
            end
            StGrant: begin
                if (!frame_n || !grant_rearb) begin
                    want = win_oh;
                end else begin
                    want = pick_valid ? pick_oh : PARK_OH;
                end
            end
            StBusy: begin
                if (pick_valid) begin
                    want = pick_oh;
                end else if (req[own_q]) begin
                    want = own_oh;
                end else if (bus_idle) begin
                    want = PARK_OH;
                end
            end
            default: want = '0;
        endcase
        gnt_next = (tmo_hit || (gnt_q != '0 && want != gnt_q)) ? '0 : want;
    end

    // FSM: ownership tracking, grant target, idle counter and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StPark;
            gnt_q   <= '0;
            win_q   <= '0;
            own_q   <= '0;
            ov_q    <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            gnt_q <= gnt_next;
            tmo_q <= tmo_hit;
            unique case (state_q)
                StPark: begin
                    if (park_start) begin
                        state_q <= StBusy;
                        own_q   <= PARK_IDX;
                        ov_q    <= 1'b1;
                        last_q  <= PARK_IDX;
                    end else if (pick_valid) begin
                        state_q <= StGrant;
                        win_q   <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                StGrant: begin
                    if (!frame_n) begin
                        state_q <= StBusy;
                        own_q   <= win_q;
                        ov_q    <= 1'b1;
                        last_q  <= win_q;
                    end else if (grant_rearb) begin
                        cnt_q <= '0;
                        if (pick_valid) begin
                            win_q <= pick_idx;
                        end else begin
                            state_q <= StPark;
                        end
                    end else if (bus_idle && gnt_q[win_q]) begin
                        cnt_q <= cnt_inc;
                    end
                end
                StBusy: begin
                    if (bus_idle) begin
                        ov_q  <= 1'b0;
                        cnt_q <= '0;
                        if (pick_valid) begin
                            state_q <= StGrant;
                            win_q   <= pick_idx;
                        end else if (req[own_q]) begin
                            state_q <= StGrant;
                            win_q   <= own_q;
                        end else begin
                            state_q <= StPark;
                        end
                    end
                end
                default: state_q <= StPark;
            endcase
        end
    end

    assign gnt_n         = ~gnt_q;
    assign owner         = own_q;
    assign owner_valid   = ov_q;
    assign timeout_pulse = tmo_q;

endmodule
